vmem_sequencer: RTL and testbench

Multi-cycle sequencer for vector loads and stores reaching the M stage. It splits one LANES-wide vector access into per-lane scalar transactions on the single-port data memory. It holds the pipeline via stall, which feeds the hazard logic driving stallE/stallM, until all lanes complete. For loads it assembles the returned lanes into one vector word for the VregwriteW path.

---
 rtl/vmem_pkg.sv | 18 +
 rtl/vmem_sequencer_if.sv | 24 ++
 rtl/vmem_addr_gen.sv | 38 +++
 rtl/vmem_sequencer.sv | 138 +++++++++++++
 tb/tb_vmem_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vmem_pkg.sv
// Shared types and default sizing for the vector memory sequencer.
// Holds the FSM state enum and lane index/byte-size constants.
package vmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_R,
        DONE
    } vmem_state_t;

    localparam int LANES      = 4;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int LANE_IDX_W = $clog2(LANES);
    localparam int LANE_BYTES = DATA_W / 8;

endpackage

// File: rtl/vmem_sequencer_if.sv
// Single-port data memory bus used by the vector memory sequencer.
// master: issues per-lane requests; slave: the data memory side.
interface vmem_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/vmem_addr_gen.sv
// Lane counter and per-lane byte address generator (wraps mod 2^ADDR_W).
// Ports: clk, reset (sync, active-low), i_clr, i_inc, i_base -> o_lane, o_last, o_addr.
module vmem_addr_gen #(
    parameter int LANES  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_clr,
    input  logic                     i_inc,
    input  logic [ADDR_W-1:0]        i_base,
    output logic [$clog2(LANES)-1:0] o_lane,
    output logic                     o_last,
    output logic [ADDR_W-1:0]        o_addr
);
    localparam int IW    = $clog2(LANES);
    localparam int BYTES = DATA_W / 8;

    logic [IW-1:0]     r_lane;
    logic [ADDR_W-1:0] w_off;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_lane <= '0;
        end else if (i_clr) begin
            r_lane <= '0;
        end else if (i_inc) begin
            r_lane <= r_lane + 1'b1;
        end
    end

    // Truncation to ADDR_W gives the required address wrap-around.
    assign w_off  = ADDR_W'(r_lane) * ADDR_W'(BYTES);
    assign o_addr = i_base + w_off;
    assign o_lane = r_lane;
    assign o_last = (r_lane == IW'(LANES - 1));
endmodule

// File: rtl/vmem_sequencer.sv
// Splits one vector load/store in M into per-lane scalar memory accesses.
// Ports: clk, reset, reqM/writeM/baseaddrM/wdataM in; bus (memory master); stall, vdone, rdataW out.
module vmem_sequencer
    import vmem_pkg::*;
#(
    parameter int LANES  = vmem_pkg::LANES,
    parameter int DATA_W = vmem_pkg::DATA_W,
    parameter int ADDR_W = vmem_pkg::ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reqM,
    input  logic                    writeM,
    input  logic [ADDR_W-1:0]       baseaddrM,
    input  logic [LANES*DATA_W-1:0] wdataM,
    vmem_sequencer_if.master        bus,
    output logic                    stall,
    output logic                    vdone,
    output logic [LANES*DATA_W-1:0] rdataW
);
    localparam int IW = $clog2(LANES);

    vmem_state_t             r_state;
    vmem_state_t             w_next;
    logic [ADDR_W-1:0]       r_base;
    logic [LANES*DATA_W-1:0] r_wdata;
    logic                    r_write;
    logic [LANES*DATA_W-1:0] r_rdata;

    logic              w_stall;
    logic              w_we;
    logic              w_re;
    logic              w_vdone;
    logic              w_clr;
    logic              w_inc;
    logic              w_cap;
    logic [IW-1:0]     w_lane;
    logic              w_last;
    logic [ADDR_W-1:0] w_addr;

    vmem_addr_gen #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_clr),
        .i_inc  (w_inc),
        .i_base (r_base),
        .o_lane (w_lane),
        .o_last (w_last),
        .o_addr (w_addr)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_clr) begin
                r_base  <= baseaddrM;
                r_wdata <= wdataM;
                r_write <= writeM;
                r_rdata <= '0;
            end
            if (w_cap) begin
                r_rdata[int'(w_lane)*DATA_W +: DATA_W] <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        w_we    = 1'b0;
        w_re    = 1'b0;
        w_vdone = 1'b0;
        w_clr   = 1'b0;
        w_inc   = 1'b0;
        w_cap   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (reqM) begin
                    w_stall = 1'b1;
                    w_clr   = 1'b1;
                    w_next  = ISSUE;
                end
            end
            ISSUE: begin
                w_stall = 1'b1;
                w_we    = r_write;
                w_re    = !r_write;
                if (bus.mem_ready) begin
                    if (!r_write) begin
                        w_next = WAIT_R;
                    end else if (w_last) begin
                        w_next = DONE;
                    end else begin
                        w_inc = 1'b1;
                    end
                end
            end
            WAIT_R: begin
                w_stall = 1'b1;
                if (bus.mem_rvalid) begin
                    w_cap = 1'b1;
                    if (w_last) begin
                        w_next = DONE;
                    end else begin
                        w_inc  = 1'b1;
                        w_next = ISSUE;
                    end
                end
            end
            DONE: begin
                // Stall drops here so the instruction leaves M.
                w_vdone = 1'b1;
                w_next  = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign bus.mem_addr  = w_addr;
    assign bus.mem_wdata = r_wdata[int'(w_lane)*DATA_W +: DATA_W];
    assign bus.mem_we    = w_we;
    assign bus.mem_re    = w_re;
    assign stall         = w_stall;
    assign vdone         = w_vdone;
    assign rdataW        = r_rdata;
endmodule

// File: tb/tb_vmem_sequencer.sv
// Directed self-checking bench for vmem_sequencer.
// Memory replies one cycle after each accepted read with 0xA0 + address[3:2].
module tb_vmem_sequencer;
    logic         clk = 1'b0;
    logic         reset;
    logic         reqM;
    logic         writeM;
    logic [31:0]  baseaddrM;
    logic [127:0] wdataM;
    logic         stall;
    logic         vdone;
    logic [127:0] rdataW;

    int n_cmp = 0;
    int n_bad = 0;

    int stall_cnt;
    int vd_cyc;
    logic stall_c1;
    logic stall_done;
    logic [31:0] iss_addr[$];
    logic [31:0] iss_data[$];
    logic [31:0] acc_addr[$];
    logic [31:0] acc_data[$];
    logic        pend;
    logic [31:0] pend_data;

    always #5 clk = ~clk;

    vmem_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    vmem_sequencer #(
        .LANES  (4),
        .DATA_W (32),
        .ADDR_W (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .reqM      (reqM),
        .writeM    (writeM),
        .baseaddrM (baseaddrM),
        .wdataM    (wdataM),
        .bus       (bus),
        .stall     (stall),
        .vdone     (vdone),
        .rdataW    (rdataW)
    );

    task automatic run_op(input logic w, input logic [31:0] b,
                          input logic [127:0] d, input int hold_lane,
                          input int hold_n, input bit keep_req,
                          input int abort_lane, output bit aborted);
        int   lanes_acc;
        int   hold_left;
        logic acc;
        bit   do_abort;
        lanes_acc = 0;
        hold_left = hold_n;
        do_abort  = 0;
        aborted   = 0;
        stall_cnt = 0;
        vd_cyc    = 0;
        stall_c1  = 1'b0;
        stall_done = 1'b1;
        iss_addr.delete();
        iss_data.delete();
        acc_addr.delete();
        acc_data.delete();
        reqM      = 1'b1;
        writeM    = w;
        baseaddrM = b;
        wdataM    = d;
        for (int c = 1; c <= 60; c++) begin
            #1;
            if ((bus.mem_we || bus.mem_re) && lanes_acc == hold_lane && hold_left > 0) begin
                bus.mem_ready = 1'b0;
                hold_left--;
            end else begin
                bus.mem_ready = 1'b1;
            end
            #1;
            if (stall) stall_cnt++;
            if (c == 1) stall_c1 = stall;
            if (bus.mem_we || bus.mem_re) begin
                iss_addr.push_back(bus.mem_addr);
                iss_data.push_back(bus.mem_wdata);
            end
            acc = (bus.mem_we || bus.mem_re) && bus.mem_ready;
            if (acc) begin
                acc_addr.push_back(bus.mem_addr);
                acc_data.push_back(bus.mem_wdata);
            end
            if (acc && bus.mem_re && abort_lane == lanes_acc) do_abort = 1;
            pend      = acc && bus.mem_re;
            pend_data = 32'hA0 + ((bus.mem_addr >> 2) & 32'h3);
            if (acc) lanes_acc++;
            if (vdone) begin
                vd_cyc     = c;
                stall_done = stall;
            end
            @(posedge clk);
            #1;
            if (!keep_req) reqM = 1'b0;
            bus.mem_rvalid = pend && !do_abort;
            bus.mem_rdata  = pend_data;
            if (do_abort) begin
                reset = 1'b0;
                @(posedge clk);
                #1;
                reset = 1'b1;
                bus.mem_rvalid = 1'b0;
                #1;
                aborted = 1;
                break;
            end
            if (vd_cyc != 0) break;
        end
        if (vd_cyc == 0 && !aborted) begin
            n_cmp++;
            n_bad++;
            $display("FAIL op_timeout got no vdone want vdone within 60 cycles");
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        reqM = 1'b0;
        writeM = 1'b0;
        baseaddrM = 32'h0;
        wdataM = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %0b want 0", stall); end
        n_cmp++;
        if (bus.mem_we !== 1'b0 || bus.mem_re !== 1'b0) begin
            n_bad++; $display("FAIL reset_req got we=%0b re=%0b want 0 0", bus.mem_we, bus.mem_re);
        end
        n_cmp++;
        if (vdone !== 1'b0) begin n_bad++; $display("FAIL reset_vdone got %0b want 0", vdone); end
        n_cmp++;
        if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
            n_bad++; $display("FAIL reset_bus got a=%0h d=%0h want 0 0", bus.mem_addr, bus.mem_wdata);
        end
        n_cmp++;
        if (rdataW !== 128'h0) begin n_bad++; $display("FAIL reset_rdataW got %0h want 0", rdataW); end
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_store();
        bit ab;
        run_op(1'b1, 32'h100, {32'd4, 32'd3, 32'd2, 32'd1}, -1, 0, 0, -1, ab);
        n_cmp++;
        if (stall_cnt != 5) begin n_bad++; $display("FAIL st_stall got %0d want 5", stall_cnt); end
        n_cmp++;
        if (vd_cyc != 6) begin n_bad++; $display("FAIL st_vdone got %0d want 6", vd_cyc); end
        n_cmp++;
        if (stall_done !== 1'b0) begin n_bad++; $display("FAIL st_stall_done got %0b want 0", stall_done); end
        n_cmp++;
        if (iss_addr.size() != 4) begin n_bad++; $display("FAIL st_issues got %0d want 4", iss_addr.size()); end
        n_cmp++;
        if (acc_addr.size() != 4) begin
            n_bad++; $display("FAIL st_accepts got %0d want 4", acc_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (acc_addr[i] !== 32'h100 + 32'(4*i) || acc_data[i] !== 32'(i+1)) begin
                    n_bad++;
                    $display("FAIL st_lane%0d got a=%0h d=%0h want a=%0h d=%0h", i,
                             acc_addr[i], acc_data[i], 32'h100 + 32'(4*i), i+1);
                end
            end
        end
    endtask

    task automatic test_load();
        bit ab;
        run_op(1'b0, 32'h200, '0, -1, 0, 0, -1, ab);
        n_cmp++;
        if (stall_cnt != 9) begin n_bad++; $display("FAIL ld_stall got %0d want 9", stall_cnt); end
        n_cmp++;
        if (vd_cyc != 10) begin n_bad++; $display("FAIL ld_vdone got %0d want 10", vd_cyc); end
        n_cmp++;
        if (rdataW !== 128'h000000A3_000000A2_000000A1_000000A0) begin
            n_bad++; $display("FAIL ld_rdataW got %h want 000000a3000000a2000000a1000000a0", rdataW);
        end
        n_cmp++;
        if (acc_addr.size() != 4 || acc_addr[3] !== 32'h20C) begin
            n_bad++; $display("FAIL ld_addr got n=%0d last=%0h want n=4 last=20c", acc_addr.size(), acc_addr[3]);
        end
        #8;
        n_cmp++;
        if (rdataW !== 128'h000000A3_000000A2_000000A1_000000A0) begin
            n_bad++; $display("FAIL ld_rdataW_hold got %h want a3..a0", rdataW);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ready_hold();
        bit ab;
        logic [31:0] exp_d [4];
        exp_d = '{32'h11, 32'h22, 32'h33, 32'h44};
        run_op(1'b1, 32'h500, {32'h44, 32'h33, 32'h22, 32'h11}, 1, 3, 0, -1, ab);
        n_cmp++;
        if (iss_addr.size() != 7) begin
            n_bad++; $display("FAIL hold_issues got %0d want 7", iss_addr.size());
        end else begin
            for (int i = 1; i <= 4; i++) begin
                n_cmp++;
                if (iss_addr[i] !== 32'h504 || iss_data[i] !== 32'h22) begin
                    n_bad++;
                    $display("FAIL hold_cyc%0d got a=%0h d=%0h want a=504 d=22", i, iss_addr[i], iss_data[i]);
                end
            end
        end
        n_cmp++;
        if (stall_cnt != 8) begin n_bad++; $display("FAIL hold_stall got %0d want 8", stall_cnt); end
        n_cmp++;
        if (vd_cyc != 9) begin n_bad++; $display("FAIL hold_vdone got %0d want 9", vd_cyc); end
        n_cmp++;
        if (acc_data.size() != 4) begin
            n_bad++; $display("FAIL hold_accepts got %0d want 4", acc_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (acc_data[i] !== exp_d[i] || acc_addr[i] !== 32'h500 + 32'(4*i)) begin
                    n_bad++;
                    $display("FAIL hold_lane%0d got a=%0h d=%0h want a=%0h d=%0h", i,
                             acc_addr[i], acc_data[i], 32'h500 + 32'(4*i), exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        bit ab;
        logic [31:0] exp_a [4];
        exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        run_op(1'b0, 32'hFFFF_FFF8, '0, -1, 0, 0, -1, ab);
        n_cmp++;
        if (acc_addr.size() != 4) begin
            n_bad++; $display("FAIL wrap_accepts got %0d want 4", acc_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (acc_addr[i] !== exp_a[i]) begin
                    n_bad++; $display("FAIL wrap_lane%0d got %0h want %0h", i, acc_addr[i], exp_a[i]);
                end
            end
        end
        n_cmp++;
        if (rdataW !== 128'h000000A1_000000A0_000000A3_000000A2) begin
            n_bad++; $display("FAIL wrap_rdataW got %h want 000000a1000000a0000000a3000000a2", rdataW);
        end
    endtask

    task automatic test_reset_abort();
        bit ab;
        run_op(1'b0, 32'h300, '0, -1, 0, 0, 2, ab);
        n_cmp++;
        if (!ab) begin n_bad++; $display("FAIL abort_reached got 0 want 1"); end
        n_cmp++;
        if (stall !== 1'b0 || bus.mem_re !== 1'b0 || vdone !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_outs got st=%0b re=%0b vd=%0b want 0 0 0", stall, bus.mem_re, vdone);
        end
        n_cmp++;
        if (rdataW !== 128'h0) begin n_bad++; $display("FAIL abort_rdataW got %h want 0", rdataW); end
        n_cmp++;
        if (bus.mem_addr !== 32'h0) begin n_bad++; $display("FAIL abort_addr got %0h want 0", bus.mem_addr); end
        @(posedge clk);
        #1;
        run_op(1'b0, 32'h400, '0, -1, 0, 0, -1, ab);
        n_cmp++;
        if (acc_addr.size() != 4 || acc_addr[0] !== 32'h400) begin
            n_bad++; $display("FAIL abort_restart got n=%0d a0=%0h want n=4 a0=400", acc_addr.size(), acc_addr[0]);
        end
        n_cmp++;
        if (vd_cyc != 10) begin n_bad++; $display("FAIL abort_restart_vdone got %0d want 10", vd_cyc); end
        n_cmp++;
        if (rdataW !== 128'h000000A3_000000A2_000000A1_000000A0) begin
            n_bad++; $display("FAIL abort_restart_rdataW got %h want a3..a0", rdataW);
        end
    endtask

    task automatic test_back_to_back();
        bit ab;
        run_op(1'b1, 32'h600, {32'hD4, 32'hD3, 32'hD2, 32'hD1}, -1, 0, 1, -1, ab);
        n_cmp++;
        if (vd_cyc != 6) begin n_bad++; $display("FAIL b2b_first_vdone got %0d want 6", vd_cyc); end
        n_cmp++;
        if (stall_done !== 1'b0) begin n_bad++; $display("FAIL b2b_done_stall got %0b want 0", stall_done); end
        n_cmp++;
        if (acc_addr.size() != 4 || acc_data[3] !== 32'hD4) begin
            n_bad++; $display("FAIL b2b_first_data got n=%0d d3=%0h want n=4 d3=d4", acc_addr.size(), acc_data[3]);
        end
        run_op(1'b1, 32'h700, {32'hE4, 32'hE3, 32'hE2, 32'hE1}, -1, 0, 0, -1, ab);
        n_cmp++;
        if (stall_c1 !== 1'b1) begin n_bad++; $display("FAIL b2b_stall_rise got %0b want 1", stall_c1); end
        n_cmp++;
        if (vd_cyc != 6) begin n_bad++; $display("FAIL b2b_second_vdone got %0d want 6", vd_cyc); end
        n_cmp++;
        if (acc_addr.size() != 4 || acc_addr[0] !== 32'h700 || acc_data[0] !== 32'hE1) begin
            n_bad++;
            $display("FAIL b2b_second_lane0 got n=%0d a=%0h d=%0h want n=4 a=700 d=e1",
                     acc_addr.size(), acc_addr[0], acc_data[0]);
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_ready_hold();
        test_wrap();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
